// File: rtl/pin_matrix_mux.sv
// pin_matrix_mux
// Routes NUM_SRC function signals onto NUM_PIN header pins through a
// double-buffered routing table. Software fills the shadow table, then a
// commit blanks every pin whose routing changes for GUARD_CYCLES cycles,
// copies shadow into active in a single APPLY cycle and returns to IDLE.
// Pins whose routing is unchanged keep driving throughout.
//
// Ports
//   clock       sole clock, rising edge
//   reset       synchronous active-high reset
//   src_out     function signals to route
//   cfg_wr      shadow-table write strobe (cfg_addr, cfg_sel)
//   cfg_addr    pin index for writes and for cfg_rdata readback
//   cfg_sel     routing code: 0 = pin released, k = src_out[k-1]
//   cfg_commit  request to apply the shadow table
//   cfg_busy    commit in progress (BLANK or APPLY)
//   cfg_err     one-cycle pulse after a rejected write or commit
//   cfg_rdata   registered active code of pin cfg_addr (0 if out of range)
//   pin_out     registered pin drive value
//   pin_oe      registered pin output enable (tristate lives in top level)
//   pin_in      raw pin levels
//   pin_sync    pin_in after a 2-flop synchronizer
//
// ADDR_W defaults to clog2(NUM_PIN); it may be widened so that addresses
// beyond the last pin can be presented and rejected.
//
// state | meaning
// IDLE  | accepting writes and commits
// BLANK | changed pins forced low/released, guard counter running
// APPLY | active <= shadow, one cycle

module pin_matrix_mux #(
  parameter int NUM_SRC      = 8,
  parameter int NUM_PIN      = 26,
  parameter int GUARD_CYCLES = 4,
  parameter int SEL_W        = $clog2(NUM_SRC + 1),
  parameter int ADDR_W       = $clog2(NUM_PIN),
  parameter logic [NUM_PIN*SEL_W-1:0] DEFAULT_MAP = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_out,
  input  logic               cfg_wr,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [SEL_W-1:0]   cfg_sel,
  input  logic               cfg_commit,
  output logic               cfg_busy,
  output logic               cfg_err,
  output logic [SEL_W-1:0]   cfg_rdata,
  output logic [NUM_PIN-1:0] pin_out,
  output logic [NUM_PIN-1:0] pin_oe,
  input  logic [NUM_PIN-1:0] pin_in,
  output logic [NUM_PIN-1:0] pin_sync
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_APPLY = 2'd2;

  // BLANK lasts while the counter walks GUARD_CYCLES-1 .. 0
  localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES - 1);

  logic [SEL_W-1:0]   shadow     [NUM_PIN];
  logic [SEL_W-1:0]   active     [NUM_PIN];
  logic [SEL_W-1:0]   shadow_nxt [NUM_PIN];
  logic [1:0]         state;
  logic [7:0]         guard_cnt;
  logic               idle;
  logic               blank;
  logic               wr_ok;
  logic               wr_bad;
  logic               commit_bad;
  logic               diff_nxt;
  logic [NUM_PIN-1:0] mask;
  logic [NUM_PIN-1:0] src_bit;
  logic [NUM_PIN-1:0] pin_out_nxt;
  logic [NUM_PIN-1:0] pin_oe_nxt;
  logic [SEL_W-1:0]   rdata_nxt;
  logic [NUM_PIN-1:0] sync_q1;

  assign idle       = (state == ST_IDLE);
  assign blank      = (state == ST_BLANK);
  assign cfg_busy   = !idle;
  assign wr_ok      = cfg_wr && idle && (int'(cfg_addr) < NUM_PIN) &&
                      (int'(cfg_sel) <= NUM_SRC);
  assign wr_bad     = cfg_wr && !wr_ok;
  assign commit_bad = cfg_commit && !idle;

  // shadow_nxt includes a same-cycle write so a simultaneous commit
  // decides on blanking against the updated table.
  always_comb begin
    diff_nxt = 1'b0;
    for (int p = 0; p < NUM_PIN; p++) begin
      shadow_nxt[p] = shadow[p];
      if (wr_ok && (int'(cfg_addr) == p)) shadow_nxt[p] = cfg_sel;
      mask[p] = (shadow[p] != active[p]);
      if (shadow_nxt[p] != active[p]) diff_nxt = 1'b1;
    end
  end

  always_comb begin
    rdata_nxt = '0;
    for (int p = 0; p < NUM_PIN; p++) begin
      src_bit[p] = 1'b0;
      for (int k = 1; k <= NUM_SRC; k++) begin
        if (int'(active[p]) == k) src_bit[p] = src_out[k-1];
      end
      pin_oe_nxt[p]  = (active[p] != '0) && !(blank && mask[p]);
      pin_out_nxt[p] = pin_oe_nxt[p] && src_bit[p];
      if (int'(cfg_addr) == p) rdata_nxt = active[p];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int p = 0; p < NUM_PIN; p++) begin
        shadow[p] <= DEFAULT_MAP[p*SEL_W +: SEL_W];
        active[p] <= DEFAULT_MAP[p*SEL_W +: SEL_W];
      end
      state     <= ST_IDLE;
      guard_cnt <= '0;
      cfg_err   <= 1'b0;
      cfg_rdata <= '0;
      pin_out   <= '0;
      pin_oe    <= '0;
      sync_q1   <= '0;
      pin_sync  <= '0;
    end else begin
      for (int p = 0; p < NUM_PIN; p++) shadow[p] <= shadow_nxt[p];
      cfg_err   <= wr_bad || commit_bad;
      cfg_rdata <= rdata_nxt;
      pin_out   <= pin_out_nxt;
      pin_oe    <= pin_oe_nxt;
      sync_q1   <= pin_in;
      pin_sync  <= sync_q1;
      case (state)
        ST_IDLE: begin
          if (cfg_commit) begin
            if (diff_nxt) begin
              state     <= ST_BLANK;
              guard_cnt <= GUARD_LOAD;
            end else begin
              state <= ST_APPLY;
            end
          end
        end
        ST_BLANK: begin
          if (guard_cnt == 8'd0) state <= ST_APPLY;
          else guard_cnt <= guard_cnt - 8'd1;
        end
        ST_APPLY: begin
          for (int p = 0; p < NUM_PIN; p++) active[p] <= shadow[p];
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pin_matrix_mux.sv
module tb_pin_matrix_mux;
  localparam int NS = 8;
  localparam int NP = 16;
  localparam int G  = 3;
  localparam int SW = 4;
  localparam int AW = 5;
  localparam logic [NP*SW-1:0] DMAP = 64'h0000_0002_0100_0000;

  logic          clock = 1'b0;
  logic          reset;
  logic [NS-1:0] src_out;
  logic          cfg_wr;
  logic [AW-1:0] cfg_addr;
  logic [SW-1:0] cfg_sel;
  logic          cfg_commit;
  logic          cfg_busy;
  logic          cfg_err;
  logic [SW-1:0] cfg_rdata;
  logic [NP-1:0] pin_out;
  logic [NP-1:0] pin_oe;
  logic [NP-1:0] pin_in;
  logic [NP-1:0] pin_sync;

  always #5 clock = ~clock;

  pin_matrix_mux #(
    .NUM_SRC(NS), .NUM_PIN(NP), .GUARD_CYCLES(G), .ADDR_W(AW), .DEFAULT_MAP(DMAP)
  ) dut (
    .clock(clock), .reset(reset), .src_out(src_out), .cfg_wr(cfg_wr),
    .cfg_addr(cfg_addr), .cfg_sel(cfg_sel), .cfg_commit(cfg_commit),
    .cfg_busy(cfg_busy), .cfg_err(cfg_err), .cfg_rdata(cfg_rdata),
    .pin_out(pin_out), .pin_oe(pin_oe), .pin_in(pin_in), .pin_sync(pin_sync)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: tables as int arrays, the commit tracked as a timeline
  // of edge numbers (commit edge -> edge at which active takes shadow).
  int m_sh [NP];
  int m_ac [NP];
  int edge_n = 0;
  bit pend = 1'b0;
  int apply_edge = 0;
  logic [NP-1:0] e_out, e_oe, e_s1, e_s2, e_s1_old;
  logic          e_err, e_busy;
  logic [SW-1:0] e_rd;

  function automatic int dcode(int p);
    logic [NP*SW-1:0] t;
    t = DMAP >> (p * SW);
    return int'(t[SW-1:0]);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit busy, blank, diff, m;
    int a, s;
    logic [NS-1:0] sh;
    edge_n++;
    if (reset) begin
      for (int p = 0; p < NP; p++) begin
        m_sh[p] = dcode(p);
        m_ac[p] = dcode(p);
      end
      pend = 1'b0;
      e_out = '0; e_oe = '0; e_err = 1'b0; e_rd = '0;
      e_s1 = '0; e_s2 = '0; e_busy = 1'b0;
      return;
    end
    busy  = pend && (edge_n <= apply_edge);
    blank = busy && (edge_n < apply_edge);
    for (int p = 0; p < NP; p++) begin
      m = (m_sh[p] != m_ac[p]);
      e_oe[p] = (m_ac[p] != 0) && !(blank && m);
      sh = src_out >> ((m_ac[p] > 0) ? m_ac[p] - 1 : 0);
      e_out[p] = e_oe[p] && sh[0];
    end
    a = int'(cfg_addr);
    s = int'(cfg_sel);
    e_rd = '0;
    if (a < NP) e_rd = SW'(m_ac[a]);
    e_err = (cfg_wr && (busy || a >= NP || s > NS)) || (cfg_commit && busy);
    e_s1_old = e_s1;
    e_s1 = pin_in;
    e_s2 = e_s1_old;
    if (busy && edge_n == apply_edge) begin
      for (int p = 0; p < NP; p++) m_ac[p] = m_sh[p];
      pend = 1'b0;
    end
    if (!busy && cfg_wr && a < NP && s <= NS) m_sh[a] = s;
    if (!busy && cfg_commit) begin
      diff = 1'b0;
      for (int p = 0; p < NP; p++) if (m_sh[p] != m_ac[p]) diff = 1'b1;
      pend = 1'b1;
      apply_edge = edge_n + (diff ? G + 1 : 1);
    end
    e_busy = pend && (edge_n + 1 <= apply_edge);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    chk("pin_out", 64'(pin_out), 64'(e_out));
    chk("pin_oe", 64'(pin_oe), 64'(e_oe));
    chk("cfg_err", 64'(cfg_err), 64'(e_err));
    chk("cfg_busy", 64'(cfg_busy), 64'(e_busy));
    chk("cfg_rdata", 64'(cfg_rdata), 64'(e_rd));
    chk("pin_sync", 64'(pin_sync), 64'(e_s2));
  endtask

  task automatic idle_inputs();
    cfg_wr = 1'b0; cfg_commit = 1'b0; cfg_addr = '0; cfg_sel = '0;
  endtask

  initial begin
    reset = 1'b1; src_out = 8'h03; pin_in = '0;
    idle_inputs();
    tick(); tick();
    chk("rst_oe", 64'(pin_oe), 64'h0);
    chk("rst_busy", 64'(cfg_busy), 64'h0);

    // reset release, src 0x03
    reset = 1'b0; pin_in = 16'hA5C3;
    tick();
    chk("r041_oe", 64'(pin_oe), 64'h0140);
    chk("r041_out", 64'(pin_out), 64'h0140);
    chk("r041_busy", 64'(cfg_busy), 64'h0);

    // write pin6=5, commit with src[4]=1 and src[0] toggling
    src_out = 8'h11;
    cfg_wr = 1'b1; cfg_addr = 5'd6; cfg_sel = 4'd5;
    tick();
    idle_inputs(); cfg_commit = 1'b1; src_out[0] = ~src_out[0];
    tick();
    chk("r042_busy0", 64'(cfg_busy), 64'h1);
    cfg_commit = 1'b0;
    for (int i = 0; i < G; i++) begin
      src_out[0] = ~src_out[0];
      tick();
      chk("r042_oe6", 64'(pin_oe[6]), 64'h0);
      chk("r042_out6", 64'(pin_out[6]), 64'h0);
      chk("r042_oe8", 64'(pin_oe[8]), 64'h1);
      chk("r042_busy", 64'(cfg_busy), 64'h1);
    end
    src_out[0] = ~src_out[0];
    tick();
    chk("r042_done", 64'(cfg_busy), 64'h0);
    src_out[0] = ~src_out[0];
    tick();
    chk("r042_new6", 64'({pin_oe[6], pin_out[6]}), 64'h3);

    // rejected writes
    cfg_wr = 1'b1; cfg_addr = 5'd2; cfg_sel = 4'd9;
    tick();
    chk("r043_sel_err", 64'(cfg_err), 64'h1);
    idle_inputs(); cfg_addr = 5'd2;
    tick();
    chk("r043_err_clr", 64'(cfg_err), 64'h0);
    cfg_wr = 1'b1; cfg_addr = 5'd16; cfg_sel = 4'd1;
    tick();
    chk("r043_addr_err", 64'(cfg_err), 64'h1);
    idle_inputs(); cfg_addr = 5'd16;
    tick();
    chk("r043_rd_oor", 64'(cfg_rdata), 64'h0);
    // valid write pin2=1, commit, then commit + write while busy
    cfg_wr = 1'b1; cfg_addr = 5'd2; cfg_sel = 4'd1;
    tick();
    idle_inputs(); cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b1; cfg_wr = 1'b1; cfg_addr = 5'd2; cfg_sel = 4'd4;
    tick();
    chk("r043_busy_err", 64'(cfg_err), 64'h1);
    idle_inputs(); cfg_addr = 5'd2;
    for (int i = 0; i < 5; i++) tick();
    chk("r043_rdata", 64'(cfg_rdata), 64'h1);
    chk("r043_idle", 64'(cfg_busy), 64'h0);

    // commit without change
    cfg_commit = 1'b1;
    tick();
    chk("r044_busy1", 64'(cfg_busy), 64'h1);
    chk("r044_oe_a", 64'(pin_oe), 64'h0144);
    cfg_commit = 1'b0;
    tick();
    chk("r044_busy0", 64'(cfg_busy), 64'h0);
    chk("r044_oe_b", 64'(pin_oe), 64'h0144);

    // same-cycle write pin3=2 + commit; fan-out with pin8
    src_out = 8'h12;
    cfg_wr = 1'b1; cfg_addr = 5'd3; cfg_sel = 4'd2; cfg_commit = 1'b1;
    tick();
    idle_inputs();
    for (int i = 0; i < G; i++) begin
      src_out[0] = ~src_out[0];
      tick();
      chk("r045_oe3", 64'(pin_oe[3]), 64'h0);
      chk("r045_out8", 64'(pin_out[8]), 64'h1);
    end
    tick(); tick();
    chk("r045_fan", 64'({pin_out[3], pin_out[8], pin_oe[3]}), 64'h7);

    // reset during second BLANK cycle
    cfg_wr = 1'b1; cfg_addr = 5'd6; cfg_sel = 4'd3;
    tick();
    idle_inputs(); cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("r046_busy", 64'(cfg_busy), 64'h0);
    reset = 1'b0; src_out = 8'h01; cfg_addr = 5'd6;
    tick();
    chk("r046_pin6", 64'({pin_oe[6], pin_out[6]}), 64'h3);
    chk("r046_rdata", 64'(cfg_rdata), 64'h1);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      src_out    = NS'($urandom);
      pin_in     = NP'($urandom);
      cfg_wr     = ($urandom_range(0, 2) == 0);
      cfg_addr   = AW'($urandom_range(0, 17));
      cfg_sel    = SW'($urandom_range(0, 9));
      cfg_commit = ($urandom_range(0, 7) == 0);
      reset      = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pin_matrix_mux.md
PIN_MATRIX_MUX -- requirements
Module: pin_matrix_mux

Interface
REQ-001 Parameter NUM_SRC, default 8: number of function output signals (motor/brush phases).
REQ-002 Parameter NUM_PIN, default 26: number of header pins served.
REQ-003 Parameter GUARD_CYCLES, default 4, legal range 1..255: blanking length in clock cycles.
REQ-004 Parameter DEFAULT_MAP, default all zero: flattened NUM_PIN x SEL_W reset routing table, where SEL_W = clog2(NUM_SRC+1) and ADDR_W = clog2(NUM_PIN).
REQ-005 clock  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 src_out  in  NUM_SRC  function signals to route.
REQ-008 cfg_wr  in  1  shadow-table write strobe.
REQ-009 cfg_addr  in  ADDR_W  pin index for write and readback.
REQ-010 cfg_sel  in  SEL_W  routing code: 0 = pin released, k = src_out[k-1].
REQ-011 cfg_commit  in  1  request to apply the shadow table.
REQ-012 cfg_busy  out  1  commit in progress.
REQ-013 cfg_err  out  1  one-cycle pulse on a rejected write or commit.
REQ-014 cfg_rdata  out  SEL_W  active code of pin cfg_addr, registered.
REQ-015 pin_out  out  NUM_PIN  pin drive value, registered.
REQ-016 pin_oe  out  NUM_PIN  pin output enable, registered; tristate buffer lives in top level.
REQ-017 pin_in  in  NUM_PIN  raw pin levels.
REQ-018 pin_sync  out  NUM_PIN  pin_in through a 2-flop synchronizer.

Function
REQ-019 Two tables SHALL exist: shadow[NUM_PIN] and active[NUM_PIN], each SEL_W bits.
REQ-020 A write (cfg_wr=1, cfg_addr<NUM_PIN, cfg_sel<=NUM_SRC, FSM in IDLE) SHALL set shadow[cfg_addr]=cfg_sel on the next edge.
REQ-021 Any write violating REQ-020 SHALL leave both tables unchanged and SHALL pulse cfg_err for 1 cycle.
REQ-022 The FSM SHALL have states IDLE, BLANK and APPLY.
REQ-023 IDLE: cfg_commit=1 SHALL go to BLANK when any shadow[p]!=active[p], else directly to APPLY.
REQ-024 BLANK SHALL last exactly GUARD_CYCLES cycles, counted by a down-counter, then go to APPLY.
REQ-025 APPLY SHALL last 1 cycle, set active=shadow, then return to IDLE.
REQ-026 cfg_busy SHALL be 1 in BLANK and APPLY, 0 in IDLE.
REQ-027 cfg_commit while busy SHALL be ignored and SHALL pulse cfg_err.
REQ-028 cfg_wr and cfg_commit asserted together in IDLE: the write SHALL be accepted and the commit SHALL use the updated shadow.
REQ-029 Change mask SHALL be mask[p] = (shadow[p]!=active[p]).
REQ-030 Each cycle, pin_out[p] SHALL be registered as 0 if active[p]==0 or (BLANK and mask[p]), else src_out[active[p]-1].
REQ-031 Each cycle, pin_oe[p] SHALL be registered as (active[p]!=0) and not (BLANK and mask[p]).
REQ-032 Unchanged pins SHALL keep toggling without interruption during BLANK and APPLY.
REQ-033 Latency src_out -> pin_out SHALL be 1 cycle.
REQ-034 The new mapping SHALL appear on pins 1 cycle after APPLY.
REQ-035 cfg_rdata SHALL be registered as active[cfg_addr], or 0 if cfg_addr>=NUM_PIN.
REQ-036 Two pins with the same code SHALL both drive that source (fan-out is legal).

Reset
REQ-037 reset=1 SHALL load shadow=active=DEFAULT_MAP and put the FSM in IDLE with the counter at 0.
REQ-038 reset=1 SHALL clear cfg_busy, cfg_err, cfg_rdata, pin_out, pin_oe and both synchronizer stages.
REQ-039 reset asserted in BLANK or APPLY SHALL abort the commit; active SHALL become DEFAULT_MAP, not shadow.
REQ-040 After reset release, pin_oe SHALL reflect DEFAULT_MAP starting the second edge.

Verification (NUM_SRC=8, NUM_PIN=16, GUARD_CYCLES=3, DEFAULT_MAP pin6=1, pin8=2, others 0)
REQ-041 Reset release, src_out=8'h03 -> pin_oe=16'h0140 and pin_out=16'h0140 one cycle later; cfg_busy=0.
REQ-042 Write pin6=5, commit, src_out[4]=1, src_out[0] toggling -> pin6 oe=0 and out=0 for exactly 3 cycles, then 1 APPLY cycle, then pin6 follows src_out[4]; pin8 uninterrupted; cfg_busy high for 4 cycles.
REQ-043 Write cfg_sel=9, write cfg_addr=16, and commit during busy -> cfg_err pulses 1 cycle each; tables and cfg_rdata unchanged.
REQ-044 Commit with shadow==active -> no blanking; cfg_busy high 1 cycle; pins undisturbed.
REQ-045 Same-cycle write pin3=2 plus commit -> pin3 blanked 3 cycles, then pin3 and pin8 both carry src_out[1].
REQ-046 reset during the 2nd BLANK cycle -> next cycle FSM in IDLE, active=DEFAULT_MAP, cfg_busy=0, pin6 restored to src_out[0].
